gate_stim_checker: RTL and testbench



---
 rtl/gate_stim_checker.sv | 129 ++++++++++++
 tb/tb_gate_stim_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_stim_checker.sv
// gate_stim_checker: drives the four {a,b} input vectors of a 2-input gate,
// holds each for HOLD_CYCLES cycles, and checks the 2-bit response against
// EXP_TABLE at the last edge of each hold window. Reports a done pulse,
// a pass flag and a saturating mismatch count.
module gate_stim_checker #(
   parameter int         HOLD_CYCLES = 10,
   parameter logic [7:0] EXP_TABLE   = 8'h6A
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] dut_out,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic [1:0] vec_idx,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count
);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

   state_t     state, state_nxt;
   logic [7:0] hold_cnt, hold_nxt;
   logic [1:0] vec_nxt;
   logic [2:0] err_nxt, err_cmp;
   logic       a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
   logic [2:0] exp_sel;
   logic [1:0] exp_bits;
   logic       mismatch;

   // expectation for the vector currently applied, and the count it would produce
   always_comb begin
      exp_sel  = {vec_idx, 1'b0};
      exp_bits = EXP_TABLE[exp_sel +: 2];
      mismatch = (dut_out != exp_bits);
      err_cmp  = err_count;
      if (mismatch && (err_count != 3'd4))
         err_cmp = err_count + 3'd1;
   end

   // next-state and next-output logic; every output is then registered
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      vec_nxt   = vec_idx;
      err_nxt   = err_count;
      pass_nxt  = pass;
      a_nxt     = a;
      b_nxt     = b;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            a_nxt    = 1'b0;
            b_nxt    = 1'b0;
            busy_nxt = 1'b0;
            if (start) begin
               state_nxt = RUN;
               vec_nxt   = 2'd0;
               err_nxt   = 3'd0;
               pass_nxt  = 1'b0;
               hold_nxt  = HOLD_RELOAD;
               busy_nxt  = 1'b1;
            end
         end
         RUN: begin
            if (hold_cnt != 8'd0) begin
               hold_nxt = hold_cnt - 8'd1;
            end else begin
               err_nxt = err_cmp;
               if (vec_idx != 2'd3) begin
                  vec_nxt  = vec_idx + 2'd1;
                  a_nxt    = vec_nxt[1];
                  b_nxt    = vec_nxt[0];
                  hold_nxt = HOLD_RELOAD;
               end else begin
                  state_nxt = FIN;
                  vec_nxt   = 2'd0;
                  a_nxt     = 1'b0;
                  b_nxt     = 1'b0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  pass_nxt  = (err_cmp == 3'd0);
               end
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            a_nxt     = 1'b0;
            b_nxt     = 1'b0;
            busy_nxt  = 1'b0;
            vec_nxt   = 2'd0;
         end
      endcase
   end

   // state and output registers; reset aborts any run without a done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         hold_cnt  <= 8'd0;
         vec_idx   <= 2'd0;
         err_count <= 3'd0;
         pass      <= 1'b0;
         a         <= 1'b0;
         b         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_nxt;
         vec_idx   <= vec_nxt;
         err_count <= err_nxt;
         pass      <= pass_nxt;
         a         <= a_nxt;
         b         <= b_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_gate_stim_checker.sv
// Bench for gate_stim_checker: randomized gate responses, expected run
// results queued at start time and checked by a negedge monitor.
module tb_gate_stim_checker;

   localparam int H = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] dut_out;
   logic       a, b, busy, done, pass;
   logic [1:0] vec_idx;
   logic [2:0] err_count;

   logic       start1 = 1'b0;
   logic [1:0] dut_out1;
   logic       a1, b1, busy1, done1, pass1;
   logic [1:0] vec_idx1;
   logic [2:0] err_count1;

   logic [1:0] resp [4];
   logic [7:0] exp_tbl = 8'h6A;

   int   vecs = 0;
   int   errs = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   bit   run_active = 1'b0;
   int   run_start = 0;
   int   last_err = 0;
   int   last_pass = 0;
   logic [3:0] sbq [$];

   assign dut_out  = resp[{a, b}];
   assign dut_out1 = {~(a1 & b1), a1 & b1};

   gate_stim_checker #(.HOLD_CYCLES(H), .EXP_TABLE(8'h6A)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
      .a(a), .b(b), .busy(busy), .vec_idx(vec_idx), .done(done),
      .pass(pass), .err_count(err_count));

   gate_stim_checker #(.HOLD_CYCLES(1), .EXP_TABLE(8'h6A)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(dut_out1),
      .a(a1), .b(b1), .busy(busy1), .vec_idx(vec_idx1), .done(done1),
      .pass(pass1), .err_count(err_count1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // monitor: expected outputs follow from the run start cycle alone
   always @(negedge clk) begin : mon
      int off, idx;
      logic [3:0] e;
      if (rst_n && mon_en) begin
         off = run_active ? (cyc - run_start) : -1;
         if (run_active && off >= 0 && off < 4*H) begin
            idx = off / H;
            chk("busy_run", busy, 1);
            chk("vec_idx", vec_idx, idx);
            chk("a", a, idx / 2);
            chk("b", b, idx % 2);
            chk("done_run", done, 0);
            if (off == 0) begin
               chk("err_clear", err_count, 0);
               chk("pass_clear", pass, 0);
            end
         end else if (run_active && off == 4*H) begin
            chk("done_fin", done, 1);
            chk("busy_fin", busy, 0);
            chk("vec_fin", vec_idx, 0);
            chk("ab_fin", {a, b}, 0);
            chk("sb_size", sbq.size(), 1);
            if (sbq.size() != 0) begin
               e = sbq.pop_front();
               chk("err_count", err_count, e[3:1]);
               chk("pass", pass, e[0]);
               last_err  = e[3:1];
               last_pass = e[0];
            end
            run_active = 1'b0;
         end else begin
            chk("busy_idle", busy, 0);
            chk("done_idle", done, 0);
            chk("ab_idle", {a, b}, 0);
            chk("vec_idle", vec_idx, 0);
            chk("err_hold", err_count, last_err);
            chk("pass_hold", pass, last_pass);
         end
      end
   end

   // mode 0 good gate, 1 bit0 stuck low, 2 forced 11, 3 random responses
   task automatic do_run(input int mode);
      int  e;
      bit  and_v;
      e = 0;
      for (int i = 0; i < 4; i++) begin
         and_v = (i == 3);
         case (mode)
            0:       resp[i] = {~and_v, and_v};
            1:       resp[i] = {~and_v, 1'b0};
            2:       resp[i] = 2'b11;
            default: resp[i] = 2'($urandom_range(0, 3));
         endcase
         if (resp[i] != 2'((exp_tbl >> (2*i)) & 8'h03)) e++;
      end
      @(posedge clk); #2;
      sbq.push_back({3'(e), (e == 0)});
      start      = 1'b1;
      run_start  = cyc + 1;
      run_active = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (run_active && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (run_active) begin
         vecs++;
         errs++;
         $display("FAIL run_timeout: done never seen within %0d cycles", n);
         run_active = 1'b0;
         sbq.delete();
      end
      @(posedge clk);
   endtask

   initial begin
      int last_done, busy_low, exp_idx, ndone;
      for (int i = 0; i < 4; i++) resp[i] = 2'b00;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ab", {a, b}, 0);
      chk("rst_vec", vec_idx, 0);
      chk("rst_err", err_count, 0);
      chk("rst_pass", pass, 0);
      chk("rst1_busy", busy1, 0);
      @(posedge clk); #2;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      do_run(0); wait_idle();
      do_run(1); wait_idle();
      do_run(2); wait_idle();

      // start pulse during a run must be ignored
      do_run(0);
      repeat (15) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      wait_idle();

      // reset in the middle of vector 2
      do_run(3);
      repeat (2*H + 3) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_vec", vec_idx, 0);
      chk("arst_ab", {a, b}, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_err", err_count, 0);
      chk("arst_pass", pass, 0);
      run_active = 1'b0;
      sbq.delete();
      last_err  = 0;
      last_pass = 0;
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      do_run(0); wait_idle();

      for (int r = 0; r < 6; r++) begin
         do_run(int'($urandom_range(0, 3)));
         wait_idle();
      end

      // HOLD_CYCLES=1 instance with start held high
      @(posedge clk); #2 start1 = 1'b1;
      last_done = -1; busy_low = 0; exp_idx = 0; ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (busy1) begin
            chk("h1_vec", vec_idx1, exp_idx);
            chk("h1_ab", {a1, b1}, exp_idx);
            exp_idx = (exp_idx + 1) % 4;
         end else begin
            busy_low++;
         end
         if (done1) begin
            ndone++;
            chk("h1_pass", pass1, 1);
            chk("h1_err", err_count1, 0);
            if (last_done >= 0) begin
               chk("h1_period", cyc - last_done, 6);
               chk("h1_busy_low", busy_low, 2);
            end
            last_done = cyc;
            busy_low  = 0;
         end
      end
      chk("h1_done_count_ok", (ndone >= 5), 1);
      start1 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
